uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter for the UART block, the sending end of the link that RX terminates. It accepts a parallel byte with a start strobe and shifts out a frame on TXD: start bit, data bits LSB first, optional parity, stop bit(s). It also drives a companion bit clock TXC whose rising edge falls mid-bit, so TXC can drive RX's RXC input directly in loopback.

Parameters:
CLK_DIV, 16, clk cycles per bit period; even, >= 2
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, parity sense when enabled: 0 = even, 1 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
DQ  in  DATA_BITS  parallel data to send; sampled only on an accepted TX_START
TX_START  in  1  start request; single-cycle or level
TXD  out  1  serial data line; idle high
TXC  out  1  bit clock; low first half of each bit period, high second half; 0 when idle
TX_BUSY  out  1  high while a frame is in progress
TX_END  out  1  one-cycle pulse at frame completion

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset values: TXD=1, TXC=0, TX_BUSY=0, TX_END=0, state=IDLE, counters=0, shift register=0.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE: when TX_START=1 at edge k, latch DQ into the shift register and enter START. From cycle k+1: TXD=0 and TX_BUSY=1. When TX_START=0, remain in IDLE.
- Each bit lasts exactly CLK_DIV cycles. The bit counter runs 0..CLK_DIV-1. TXC=0 for counts 0..CLK_DIV/2-1 and TXC=1 for the rest. TXD changes only when the counter wraps.
- DATA: send DATA_BITS bits, LSB first, shifting right on each wrap.
- PARITY: send the XOR of the latched data bits, inverted when PARITY_ODD=1.
- STOP: hold TXD=1 for STOP_BITS*CLK_DIV cycles.
- Frame length: N = CLK_DIV*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles, occupying cycles k+1..k+N.
- Frame completion, cycle k+N+1:
  - State=IDLE, TX_BUSY=0, TX_END=1 for this one cycle, TXC=0, TXD=1.
  - A TX_START in this cycle is accepted, giving back-to-back frames with no idle bit.
- TX_START while TX_BUSY=1 is ignored: no queuing, and DQ changes have no effect.
- rst asserted mid-frame: on the next edge all outputs and state return to their reset values. The partial frame is abandoned and TX_END is not pulsed.
- rst and TX_START high together: rst wins.
- The parity calculation covers only the DATA_BITS LSBs of DQ.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP), shared with a future RX FSM;
  - the constant function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  - an idle-line constant of 1.
- Sub-module uart_bit_timer, parameterised by CLK_DIV. Inputs: clk, rst, enable. Outputs: bit_done (wrap pulse) and half (drives TXC). The top-level FSM and shift register stay in uart_tx.

Test Plan:
1. CLK_DIV=4, default parameters. DQ=0xA5 with TX_START at edge 0.
   -> TXD over cycles 1..40 is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   -> TX_BUSY=1 over cycles 1..40; TX_END=1 only at cycle 41.
   -> TXC reads 0,0,1,1 within every bit.
2. PARITY_EN=1, PARITY_EN even (PARITY_ODD=0). DQ=0x07.
   -> parity bit=1; frame length 44 cycles (CLK_DIV=4).
   -> With PARITY_ODD=1, parity bit=0.
3. Busy rejection. TX_START pulsed with DQ=0x3C at cycle 10 of a frame carrying 0x81.
   -> The transmitted frame is still 0x81; no second frame follows.
4. Back-to-back. TX_START held high with DQ=0x55, then DQ=0xAA.
   -> Second start bit begins at cycle 42 with no idle-high gap.
   -> TX_END pulses at cycles 41 and 82.
5. Reset mid-frame. rst=1 at cycle 15 of a frame.
   -> Cycle 16: TXD=1, TXC=0, TX_BUSY=0, no TX_END.
   -> A following TX_START then sends a complete, correct frame.
6. Loopback. TXD->RXD and TXC->RXC into RX; send 0x00, 0xFF, 0x5A.
   -> RX DQ matches each byte, and RX_END follows each frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and frame helpers used by the TX block (and later RX).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LINE = 1'b1;

  // Total bit periods in one frame: start + data + optional parity + stop(s)
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: registered wrap pulse and mid-bit half indicator for TXC.
module uart_bit_timer #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_done,
  output logic half
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (enable && (cnt != LAST_CNT)) cnt_nxt = cnt + CW'(1);
  end

  // Flags are registered from the next count so they line up with cnt itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      half     <= 1'b0;
      bit_done <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      half     <= enable && (cnt_nxt >= HALF_CNT);
      bit_done <= enable && (cnt_nxt == LAST_CNT);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop bits, plus mid-bit TXC.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] DQ,
  input  logic                 TX_START,
  output logic                 TXD,
  output logic                 TXC,
  output logic                 TX_BUSY,
  output logic                 TX_END
);

  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic ODD_SENSE  = 1'(PARITY_ODD);
  localparam logic HAS_PARITY = (PARITY_EN != 0);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 par;
  logic                 bit_done;
  logic                 timer_en;

  assign timer_en = (state != IDLE);

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (timer_en),
    .bit_done (bit_done),
    .half     (TXC)
  );

  // Frame sequencer; TXD only moves on a bit-period wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      TXD      <= IDLE_LINE;
      TX_BUSY  <= 1'b0;
      TX_END   <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par      <= 1'b0;
    end else begin
      TX_END <= 1'b0;
      case (state)
        IDLE: begin
          if (TX_START) begin
            shreg   <= DQ;
            par     <= (^DQ) ^ ODD_SENSE;
            state   <= START;
            TXD     <= 1'b0;
            TX_BUSY <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            TXD     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              if (HAS_PARITY) begin
                state <= PARITY;
                TXD   <= par;
              end else begin
                state    <= STOP;
                TXD      <= IDLE_LINE;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            TXD      <= IDLE_LINE;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (stop_idx == LAST_STOP) begin
              state   <= IDLE;
              TX_BUSY <= 1'b0;
              TX_END  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity, busy rejection, back-to-back, reset, loopback.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0;
  logic       start_p;
  logic [7:0] dq;
  logic [2:0] txd_v, txc_v, busy_v, end_v;
  logic [1:0] sel;
  logic       txd_m, txc_m, busy_m, end_m;

  int vectors     = 0;
  int miscompares = 0;

  logic       rx_en = 1'b0;
  logic       rx_act = 1'b0;
  int         rx_n = 0;
  int         rx_frames = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .DQ(dq), .TX_START(start0),
    .TXD(txd_v[0]), .TXC(txc_v[0]), .TX_BUSY(busy_v[0]), .TX_END(end_v[0])
  );
  uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .rst(rst), .DQ(dq), .TX_START(start_p),
    .TXD(txd_v[1]), .TXC(txc_v[1]), .TX_BUSY(busy_v[1]), .TX_END(end_v[1])
  );
  uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .rst(rst), .DQ(dq), .TX_START(start_p),
    .TXD(txd_v[2]), .TXC(txc_v[2]), .TX_BUSY(busy_v[2]), .TX_END(end_v[2])
  );

  always_comb begin
    txd_m  = txd_v[sel];
    txc_m  = txc_v[sel];
    busy_m = busy_v[sel];
    end_m  = end_v[sel];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: bit index 0 = start, 1..8 data LSB first, then parity, then stop.
  function automatic logic exp_bit(input logic [7:0] d, input int idx, input int pen, input int podd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pen != 0) return (^d) ^ (podd != 0);
    return 1'b1;
  endfunction

  // Called at cycle 1 of a frame; leaves the bench sampled at the completion cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input int pen,
                             input int podd, input int poke, input logic [7:0] pdata);
    int n;
    n = int'(frame_bits(8, pen, 1)) * 4;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s txd c%0d", tag, i + 1), 8'(txd_m), 8'(exp_bit(d, i / 4, pen, podd)));
      chk($sformatf("%s txc c%0d", tag, i + 1), 8'(txc_m), 8'((i % 4) >= 2));
      chk($sformatf("%s busy c%0d", tag, i + 1), 8'(busy_m), 8'd1);
      chk($sformatf("%s end c%0d", tag, i + 1), 8'(end_m), 8'd0);
      if (i + 1 == poke) begin
        dq     = pdata;
        start0 = 1'b1;
      end
      step();
      if (i + 1 == poke) start0 = 1'b0;
    end
    chk({tag, " end_pulse"}, 8'(end_m), 8'd1);
    chk({tag, " end_busy"}, 8'(busy_m), 8'd0);
    chk({tag, " end_txd"}, 8'(txd_m), 8'd1);
    chk({tag, " end_txc"}, 8'(txc_m), 8'd0);
  endtask

  // Loopback receiver model: samples TXD on each TXC rising edge.
  always @(posedge txc_v[0]) begin
    if (rx_en) begin
      if (!rx_act) begin
        if (txd_v[0] == 1'b0) begin
          rx_act = 1'b1;
          rx_n   = 0;
        end
      end else if (rx_n < 8) begin
        rx_sh = {txd_v[0], rx_sh[7:1]};
        rx_n++;
      end else begin
        rx_act = 1'b0;
        rx_frames++;
        chk("rx stop", 8'(txd_v[0]), 8'd1);
        chk("rx qdepth", 8'(exp_q.size() > 0), 8'd1);
        if (exp_q.size() > 0) chk("rx data", rx_sh, exp_q.pop_front());
      end
    end
  end

  initial begin
    sel = 2'd0; rst = 1'b1; start0 = 1'b0; start_p = 1'b0; dq = '0;
    step(); step();
    chk("rst txd", 8'(txd_m), 8'd1);
    chk("rst txc", 8'(txc_m), 8'd0);
    chk("rst busy", 8'(busy_m), 8'd0);
    chk("rst end", 8'(end_m), 8'd0);

    // Reset beats a simultaneous start
    start0 = 1'b1;
    step();
    chk("rst_wins busy", 8'(busy_m), 8'd0);
    chk("rst_wins txd", 8'(txd_m), 8'd1);
    rst = 1'b0; start0 = 1'b0;
    step();
    chk("idle busy", 8'(busy_m), 8'd0);

    // Basic frame 0xA5
    dq = 8'hA5; start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_frame("a5", 8'hA5, 0, 0, -1, 8'h00);
    step();
    chk("a5 end_once", 8'(end_m), 8'd0);

    // Parity even then odd on 0x07
    sel = 2'd1; dq = 8'h07; start_p = 1'b1;
    step();
    start_p = 1'b0;
    check_frame("par_even", 8'h07, 1, 0, -1, 8'h00);
    sel = 2'd2; start_p = 1'b1;
    step();
    start_p = 1'b0;
    check_frame("par_odd", 8'h07, 1, 1, -1, 8'h00);
    sel = 2'd0;
    step();

    // Start while busy is ignored
    dq = 8'h81; start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_frame("busy_rej", 8'h81, 0, 0, 10, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("busy_rej idle busy %0d", i), 8'(busy_m), 8'd0);
      chk($sformatf("busy_rej idle txd %0d", i), 8'(txd_m), 8'd1);
    end

    // Back-to-back with level start
    dq = 8'h55; start0 = 1'b1;
    step();
    dq = 8'hAA;
    check_frame("b2b_1", 8'h55, 0, 0, -1, 8'h00);
    step();
    start0 = 1'b0;
    check_frame("b2b_2", 8'hAA, 0, 0, -1, 8'h00);
    step();

    // Reset mid-frame, then a clean frame
    dq = 8'hC3; start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("midrst c15 busy", 8'(busy_m), 8'd1);
    chk("midrst c15 txc", 8'(txc_m), 8'd1);
    rst = 1'b1;
    step();
    chk("midrst txd", 8'(txd_m), 8'd1);
    chk("midrst txc", 8'(txc_m), 8'd0);
    chk("midrst busy", 8'(busy_m), 8'd0);
    chk("midrst end", 8'(end_m), 8'd0);
    rst = 1'b0;
    step();
    chk("midrst after end", 8'(end_m), 8'd0);
    chk("midrst after busy", 8'(busy_m), 8'd0);
    dq = 8'h96; start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_frame("post_rst", 8'h96, 0, 0, -1, 8'h00);
    step();

    // Loopback through the receiver model
    rx_en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      logic [7:0] bytes [3];
      bytes = '{8'h00, 8'hFF, 8'h5A};
      dq = bytes[b];
      exp_q.push_back(bytes[b]);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      check_frame($sformatf("loop%0d", b), bytes[b], 0, 0, -1, 8'h00);
    end
    for (int i = 0; i < 4; i++) step();
    chk("loop frames", 8'(rx_frames), 8'd3);
    chk("loop q empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
